// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  clear;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with occupancy count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read; default is a registered 1-cycle read.
module sync_fifo_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_LEVEL   = 28,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                clock,
  input  logic                aresetn,
  sync_fifo_param_if.slave    fifo_if
);
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
`ifndef SYNC_FIFO_FWFT_EN
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
`endif

  // Acceptance uses the flags registered before the edge; clear masks both strobes.
  assign wr_acc_c = fifo_if.wr_en && !full_q  && !fifo_if.clear;
  assign rd_acc_c = fifo_if.rd_en && !empty_q && !fifo_if.clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
`ifndef SYNC_FIFO_FWFT_EN
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`endif
    if (fifo_if.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (fifo_if.wr_en && full_q)  ovf_d = 1'b1;
      if (fifo_if.rd_en && empty_q) udf_d = 1'b1;
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc_c) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
`ifndef SYNC_FIFO_FWFT_EN
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_ptr_q];
`endif
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Flags are registered from the next count so they track count exactly.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clock) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= fifo_if.wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo_if.rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign fifo_if.rd_valid = !empty_q;
`else
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign fifo_if.rd_data  = rd_data_q;
  assign fifo_if.rd_valid = rd_valid_q;
`endif

  assign fifo_if.count        = count_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.empty        = empty_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.almost_empty = ae_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = udf_q;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with independent write and read strobes, occupancy count, programmable almost-full/almost-empty thresholds and sticky error flags. It is the general-purpose buffering block for datapaths inside the `clock` domain. It is built as a circular buffer with read and write pointers, so each transfer moves no stored data.

## Interface
- `WIDTH`, 32: data word width in bits, ≥1.
- `DEPTH`, 32: number of entries; power of two, ≥2.
- `ADDR_WIDTH`, 5: pointer width; must equal log2(`DEPTH`).
- `AF_LEVEL`, 28: `almost_full` asserts when count ≥ `AF_LEVEL`; range 1..`DEPTH`.
- `AE_LEVEL`, 4: `almost_empty` asserts when count ≤ `AE_LEVEL`; range 0..`DEPTH`-1.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; has priority over `wr_en` and `rd_en`.
- `wr_en`  in  1  write strobe.
- `wr_data`  in  `WIDTH`  write data.
- `rd_en`  in  1  read/pop strobe.
- `rd_data`  out  `WIDTH`  read data.
- `rd_valid`  out  1  `rd_data` qualifier; meaning depends on mode (see Configuration).
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ `AF_LEVEL`.
- `almost_empty`  out  1  count ≤ `AE_LEVEL`.
- `count`  out  `ADDR_WIDTH`+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; set by a write attempted while full.
- `underflow`  out  1  sticky; set by a read attempted while empty.

## Operation
- **Reset values:**
  - `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
  - `rd_valid`=0, `rd_data`=0, `overflow`=0, `underflow`=0.
  - Both pointers=0. Memory contents are not reset.
- **Write accept:** `wr_en` && !`full` (`full` as registered before the edge). The word is written to `mem[wr_ptr]` and `wr_ptr` increments.
- **Read accept:** `rd_en` && !`empty` (`empty` as registered before the edge). The head word `mem[rd_ptr]` is popped and `rd_ptr` increments.
- **Pointer wrap:** both pointers wrap naturally from `DEPTH`-1 to 0 (modulo 2^`ADDR_WIDTH`).
- **Count update:** +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- **Simultaneous write and read:**
  - When full, the write is rejected, `overflow` is set and the read proceeds; count becomes `DEPTH`-1.
  - When empty, the read is rejected, `underflow` is set and the write proceeds; count becomes 1.
  - Otherwise both proceed and count is unchanged.
- **Rejected operations:** leave the memory, pointers and count untouched.
- **Sticky errors:** `overflow` and `underflow` clear only on reset or `clear`.
- **`clear`:** on the edge where it is sampled high:
  - pointers=0, count=0, `overflow`=0, `underflow`=0, `rd_valid`=0;
  - `wr_en` and `rd_en` are ignored in that cycle;
  - the flags take their reset values after the edge.
- **Reset mid-operation:** immediately forces all reset values, independent of `clock`; any in-flight read data is lost.
- **Flag derivation:** all flags are derived from the registered count only, never from the same-cycle strobes.

## Timing
- **Write to flags:** a write accepted at edge N is reflected in `count` and the flags in the cycle after edge N.
- **Write to read:** a word written at edge N is readable by a `rd_en` sampled at edge N+1 at the earliest.
- **Standard mode, read latency:** a read accepted at edge N presents `rd_data` and pulses `rd_valid` high for exactly the cycle after edge N.
- **Standard mode, output hold:** `rd_data` holds its last value when no read is accepted.
- **Throughput:** one write and one read per cycle, sustained.

## Configuration
- **Macro:** `SYNC_FIFO_FWFT_EN`.
- **Undefined (standard mode):** registered read with a 1-cycle latency, as described under Timing.
- **Defined (first-word-fall-through mode):**
  - `rd_data` = `mem[rd_ptr]` combinationally, forced to 0 while empty;
  - `rd_valid` = !`empty`;
  - `rd_en` acts as the acknowledge that pops the head;
  - a word written at edge N is visible on `rd_data` with `rd_valid`=1 in the cycle after edge N.
- **Unchanged by the macro:** the port list, the flags and the error behaviour.

## Test plan
- **Reset:** assert `aresetn`=0 mid-stream with count=7 → all outputs take their reset values asynchronously; after release, `count`=0 and `empty`=1.
- **Fill and drain:**
  - Stimulus: with defaults, write 0x0..0x1F on 32 consecutive edges, then read 32.
  - `almost_full` rises after the 28th write and `full` after the 32nd.
  - Data returns 0x0..0x1F in order, with `rd_valid` one cycle after each `rd_en`.
  - `almost_empty` rises when count reaches 4.
- **Overflow:**
  - At `full`, assert `wr_en` with 0xDEAD → `overflow`=1 and `count` stays 32.
  - Later reads return no 0xDEAD.
  - `overflow` stays 1 until `clear`.
- **Underflow with simultaneous write:** when empty, assert `wr_en` and `rd_en` together with 0xA5 → `underflow`=1, `count`=1, no `rd_valid` pulse; the next read returns 0xA5.
- **Wrap-around:** at count=16, run 100 cycles of simultaneous read and write → `count` stays 16, pointers wrap more than 3 times, and data order is preserved.
- **FWFT:** with `SYNC_FIFO_FWFT_EN` defined, write 0x11 at edge N → `rd_valid`=1 and `rd_data`=0x11 after edge N; pop with `rd_en` → `rd_valid`=0 and `rd_data`=0.
